mult_err_accum: RTL
===================

MULT_ERR_ACCUM -- requirements
Module: mult_err_accum

Interface
REQ-001 Parameters SHALL be: NSAMP_W, default 16, width of sample-count input and error counter; ACC_W, default 32, width of the error-distance sum accumulator.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  one-cycle request to begin a measurement run.
REQ-005 num_samples  input  NSAMP_W  number of samples in the run; sampled only when start is accepted.
REQ-006 in_valid  input  1  A, B and R are valid this cycle.
REQ-007 in_ready  output  1  block accepts a sample this cycle.
REQ-008 A, B  input  8 each  unsigned operands applied to the 8x8 approximate multiplier.
REQ-009 R  input  16  approximate product returned by the multiplier.
REQ-010 busy  output  1  high in RUN and DRAIN.
REQ-011 done  output  1  high while in DONE; statistics are final.
REQ-012 err_count  output  NSAMP_W  number of samples with R != A*B.
REQ-013 sum_ed  output  ACC_W  sum of |A*B - R|, unsigned.
REQ-014 max_ed  output  16  largest |A*B - R| seen in the run.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-016 In IDLE or DONE, start=1 SHALL clear err_count, sum_ed and max_ed, and latch num_samples. The FSM SHALL go to RUN, or directly to DONE if num_samples==0.
REQ-017 start SHALL be ignored in RUN and DRAIN.
REQ-018 in_ready SHALL be 1 only in RUN. A sample is accepted when in_valid and in_ready are both 1.
REQ-019 An internal accepted-sample counter SHALL increment per accepted sample. When the sample that makes the count equal the latched num_samples is accepted, the FSM SHALL move to DRAIN on the next edge, and in_ready SHALL drop that same edge.
REQ-020 The datapath SHALL be 2 stages. Stage 1 registers exact=A*B (16 bit, exact) and ed=|exact-R|. Stage 2 updates the statistics.
REQ-021 Latency: a sample accepted at edge t SHALL be reflected in all outputs after edge t+2.
REQ-022 DRAIN SHALL last exactly 2 cycles, then DONE. done rises 2 cycles after the last acceptance edge.
REQ-023 sum_ed SHALL saturate at 2^ACC_W-1. err_count SHALL saturate at 2^NSAMP_W-1. max_ed SHALL update when ed > max_ed (strict).
REQ-024 Gaps in in_valid during RUN SHALL only stall the run. Pipeline bubbles SHALL NOT modify the statistics.
REQ-025 DONE SHALL hold the statistics and done=1 until the next accepted start.

Reset
REQ-026 While rst_n=0, state SHALL be IDLE. in_ready, busy, done, err_count, sum_ed, max_ed, the counters and the pipeline valid bits SHALL all be 0.
REQ-027 Reset asserted mid-run SHALL abandon the run with no residual pipeline effect after release.
REQ-028 Data-path registers other than valid bits SHALL need no reset.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, the default NSAMP_W and ACC_W, and the product width constant (16).
REQ-030 One combinational sub-module, err_dist_unit, SHALL compute exact product and absolute distance from A, B and R. The FSM, counters and accumulators SHALL be in mult_err_accum.

Verification
REQ-031 Run with num_samples=1, sample A=15, B=15, R=224 -> err_count=1, sum_ed=1, max_ed=1; done rises 2 cycles after acceptance.
REQ-032 Run with num_samples=3, samples (255,255,65025), (0,7,0), (16,16,256) -> err_count=0, sum_ed=0, max_ed=0.
REQ-033 Run with num_samples=4, in_valid toggled 1,0,0,1,1,0,1 with ed values 5,300,2,300 -> err_count=4, sum_ed=607, max_ed=300. in_ready=0 from the edge after the 4th acceptance.
REQ-034 start with num_samples=0 -> DONE the next cycle, all statistics 0, in_ready never 1. A second start during RUN is ignored; start in DONE clears the statistics.
REQ-035 rst_n pulsed low mid-run after 2 of 5 samples -> all outputs 0 immediately. After release, a fresh run of 1 sample with ed=3 gives sum_ed=3.
REQ-036 Run with ACC_W=8 and 2 samples of ed=200 -> sum_ed=255 (saturated), max_ed=200.

Source files
------------

// File: rtl/mult_err_accum_pkg.sv
// Shared constants and FSM state type for the approximate-multiplier error accumulator.
package mult_err_accum_pkg;

  localparam int unsigned NSAMP_W_DEF = 16;
  localparam int unsigned ACC_W_DEF   = 32;
  localparam int unsigned OPND_W      = 8;
  localparam int unsigned PROD_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mult_err_accum_err_dist.sv
// Combinational exact product and absolute error distance versus the approximate result.
module err_dist_unit
  import mult_err_accum_pkg::*;
(
  input  logic [OPND_W-1:0] i_a,
  input  logic [OPND_W-1:0] i_b,
  input  logic [PROD_W-1:0] i_r,
  output logic [PROD_W-1:0] o_exact,
  output logic [PROD_W-1:0] o_ed
);

  logic [PROD_W-1:0] w_exact;

  assign w_exact = PROD_W'(i_a) * PROD_W'(i_b);
  assign o_exact = w_exact;
  assign o_ed    = (w_exact >= i_r) ? (w_exact - i_r) : (i_r - w_exact);

endmodule

// File: rtl/mult_err_accum.sv
// Measurement-run controller: accepts samples, pipes them through a 2-stage
// error datapath and accumulates mismatch count, error sum and max error.
module mult_err_accum
  import mult_err_accum_pkg::*;
#(
  parameter int unsigned NSAMP_W = NSAMP_W_DEF,
  parameter int unsigned ACC_W   = ACC_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [NSAMP_W-1:0] num_samples,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OPND_W-1:0]  A,
  input  logic [OPND_W-1:0]  B,
  input  logic [PROD_W-1:0]  R,
  output logic               busy,
  output logic               done,
  output logic [NSAMP_W-1:0] err_count,
  output logic [ACC_W-1:0]   sum_ed,
  output logic [PROD_W-1:0]  max_ed
);

  localparam int unsigned SUM_W = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;

  state_e             r_state;
  logic               r_in_ready;
  logic               r_busy;
  logic               r_done;
  logic               r_drain;
  logic [NSAMP_W-1:0] r_nsamp;
  logic [NSAMP_W-1:0] r_cnt;
  logic               r_v1;
  logic               r_mis;
  logic [PROD_W-1:0]  r_ed;
  logic [NSAMP_W-1:0] r_err;
  logic [ACC_W-1:0]   r_sum;
  logic [PROD_W-1:0]  r_max;

  logic [PROD_W-1:0]  w_exact;
  logic [PROD_W-1:0]  w_ed;
  logic               w_accept;
  logic               w_start_acc;
  logic [NSAMP_W-1:0] w_cnt_nxt;
  logic [SUM_W-1:0]   w_sum;
  logic [SUM_W-1:0]   w_sum_max;

  err_dist_unit u_edu (
    .i_a     (A),
    .i_b     (B),
    .i_r     (R),
    .o_exact (w_exact),
    .o_ed    (w_ed)
  );

  // in_ready is high exactly in RUN, so no separate state decode is needed
  assign w_accept    = in_valid & r_in_ready;
  assign w_start_acc = start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
  assign w_cnt_nxt   = r_cnt + NSAMP_W'(1);
  assign w_sum       = SUM_W'(r_sum) + SUM_W'(r_ed);
  assign w_sum_max   = SUM_W'({ACC_W{1'b1}});

  // Run-control FSM with registered handshake/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_drain    <= 1'b0;
      r_nsamp    <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_nsamp <= num_samples;
            r_cnt   <= '0;
            r_drain <= 1'b0;
            if (num_samples == '0) begin
              r_state    <= ST_DONE;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_state    <= ST_RUN;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b1;
              r_done     <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == r_nsamp) begin
              r_state    <= ST_DRAIN;
              r_in_ready <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          // Two cycles: lets the last sample clear both pipeline stages
          if (r_drain) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_drain <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1 payload: only the valid bit needs a reset
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_ed  <= w_ed;
      r_mis <= (w_exact != R);
    end
  end

  // Stage 1 valid and stage 2 statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1  <= 1'b0;
      r_err <= '0;
      r_sum <= '0;
      r_max <= '0;
    end else begin
      r_v1 <= w_accept;
      if (w_start_acc) begin
        r_err <= '0;
        r_sum <= '0;
        r_max <= '0;
      end else if (r_v1) begin
        if (r_mis && (r_err != {NSAMP_W{1'b1}})) r_err <= r_err + NSAMP_W'(1);
        r_sum <= (w_sum > w_sum_max) ? {ACC_W{1'b1}} : ACC_W'(w_sum);
        if (r_ed > r_max) r_max <= r_ed;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err_count = r_err;
  assign sum_ed    = r_sum;
  assign max_ed    = r_max;

endmodule
